// File: rtl/codec_config_sequencer.sv
// ============================================================================
// Module      : codec_config_sequencer
// Description : Walks a fixed 11-entry audio-codec register table and issues
//               each entry as a 3-byte I2C write command with retry handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module codec_config_sequencer #(
  parameter logic [7:0]  CHIP_ADDR     = 8'h34,
  parameter int unsigned STARTUP_DELAY = 1000,
  parameter int unsigned GAP_CYCLES    = 100,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic       clk,
  input  logic       KEY,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data1,
  output logic [7:0] cmd_data2,
  input  logic       xfer_done,
  input  logic       xfer_ack,
  input  logic       restart,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic [3:0] cfg_index,
  output logic [1:0] retry_cnt
);

  localparam int unsigned c_MAX_A    = (STARTUP_DELAY > GAP_CYCLES) ? STARTUP_DELAY : GAP_CYCLES;
  localparam int unsigned c_MAX_WAIT = (c_MAX_A > TIMEOUT) ? c_MAX_A : TIMEOUT;
  localparam int unsigned c_CNT_W    = (c_MAX_WAIT > 1) ? $clog2(c_MAX_WAIT) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_STARTUP_LAST = c_CNT_W'((STARTUP_DELAY > 0) ? STARTUP_DELAY - 1 : 0);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST     = c_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [3:0]         c_LAST_IDX     = 4'd10;
  localparam logic [1:0]         c_MAX_RETRY    = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_POWERUP_WAIT = 3'd0,
    S_ISSUE        = 3'd1,
    S_WAIT_DONE    = 3'd2,
    S_GAP          = 3'd3,
    S_DONE         = 3'd4,
    S_ERROR        = 3'd5
  } state_e;

  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = 16'h1E00;
      4'd1:    table_entry = 16'h0017;
      4'd2:    table_entry = 16'h0217;
      4'd3:    table_entry = 16'h0479;
      4'd4:    table_entry = 16'h0679;
      4'd5:    table_entry = 16'h0812;
      4'd6:    table_entry = 16'h0A00;
      4'd7:    table_entry = 16'h0C00;
      4'd8:    table_entry = 16'h0E42;
      4'd9:    table_entry = 16'h1000;
      4'd10:   table_entry = 16'h1201;
      default: table_entry = 16'h0000;
    endcase
  endfunction

  state_e             state_q;
  logic [c_CNT_W-1:0] cnt_q;
  logic               cmd_valid_q;
  logic [15:0]        cmd_word_q;
  logic               cfg_done_q;
  logic               cfg_error_q;
  logic [3:0]         cfg_index_q;
  logic [1:0]         retry_q;

  logic [3:0]  next_index_d;
  logic [15:0] next_word_d;

  assign next_index_d = cfg_index_q + 4'd1;
  assign next_word_d  = table_entry(next_index_d);

  // The command word is loaded whenever the index changes, so the fields are
  // already settled when ISSUE raises cmd_valid and cannot move before acceptance.
  always_ff @(posedge clk or negedge KEY) begin
    if (!KEY) begin
      state_q     <= S_POWERUP_WAIT;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_word_q  <= table_entry(4'd0);
      cfg_done_q  <= 1'b0;
      cfg_error_q <= 1'b0;
      cfg_index_q <= 4'd0;
      retry_q     <= 2'd0;
    end else begin
      case (state_q)
        S_POWERUP_WAIT: begin
          if (cnt_q == c_STARTUP_LAST) begin
            cnt_q       <= '0;
            cmd_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end else begin
            cnt_q <= cnt_q + c_CNT_ONE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          // A real completion takes priority over a timeout in the same cycle.
          if (xfer_done && xfer_ack) begin
            cnt_q   <= '0;
            retry_q <= 2'd0;
            if (cfg_index_q == c_LAST_IDX) begin
              cfg_done_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              cfg_index_q <= next_index_d;
              cmd_word_q  <= next_word_d;
              state_q     <= S_GAP;
            end
          end else if (xfer_done || (cnt_q == c_TIMEOUT_LAST)) begin
            cnt_q <= '0;
            if (retry_q == c_MAX_RETRY) begin
              cfg_error_q <= 1'b1;
              state_q     <= S_ERROR;
            end else begin
              retry_q <= retry_q + 2'd1;
              state_q <= S_GAP;
            end
          end else begin
            cnt_q <= cnt_q + c_CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt_q == c_GAP_LAST) begin
            cnt_q       <= '0;
            cmd_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end else begin
            cnt_q <= cnt_q + c_CNT_ONE;
          end
        end
        S_DONE, S_ERROR: begin
          if (restart) begin
            cfg_done_q  <= 1'b0;
            cfg_error_q <= 1'b0;
            cfg_index_q <= 4'd0;
            retry_q     <= 2'd0;
            cmd_word_q  <= table_entry(4'd0);
            cnt_q       <= '0;
            cmd_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        default: begin
          state_q     <= S_POWERUP_WAIT;
          cnt_q       <= '0;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = CHIP_ADDR;
  assign cmd_data1 = cmd_word_q[15:8];
  assign cmd_data2 = cmd_word_q[7:0];
  assign cfg_done  = cfg_done_q;
  assign cfg_error = cfg_error_q;
  assign cfg_index = cfg_index_q;
  assign retry_cnt = retry_q;

endmodule

`default_nettype wire

// File: tb/tb_codec_config_sequencer.sv
// ============================================================================
// Module      : tb_codec_config_sequencer
// Description : Scoreboard bench: directed phases push expected commands, a
//               monitor pops and checks each accepted command.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_codec_config_sequencer;

  localparam int c_STARTUP = 20;
  localparam int c_GAP     = 10;
  localparam int c_RETRY   = 3;
  localparam int c_TIMEOUT = 40;
  localparam int c_ACKDLY  = 5;
  localparam logic [7:0] c_ADDR = 8'h34;

  logic       clk, KEY, cmd_valid, cmd_ready;
  logic [7:0] cmd_addr, cmd_data1, cmd_data2;
  logic       xfer_done, xfer_ack, restart, cfg_done, cfg_error;
  logic [3:0] cfg_index;
  logic [1:0] retry_cnt;

  codec_config_sequencer #(
    .CHIP_ADDR(c_ADDR), .STARTUP_DELAY(c_STARTUP), .GAP_CYCLES(c_GAP),
    .MAX_RETRY(c_RETRY), .TIMEOUT(c_TIMEOUT)
  ) dut (
    .clk(clk), .KEY(KEY), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data1(cmd_data1), .cmd_data2(cmd_data2),
    .xfer_done(xfer_done), .xfer_ack(xfer_ack), .restart(restart),
    .cfg_done(cfg_done), .cfg_error(cfg_error), .cfg_index(cfg_index),
    .retry_cnt(retry_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] tbl [0:10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                              16'h0A00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201};

  typedef struct { int idx; int retry; int gap; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int acc_count = 0;
  int nack_idx = -1, nack_left = 0;
  int silent_idx = -1, silent_left = 0;
  int slow_idx = -1, slow_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [7:0] d1);
    for (int i = 0; i < 11; i++) if (tbl[i][15:8] == d1) return i;
    return -1;
  endfunction

  task automatic push(input int idx, input int retry, input int gap);
    exp_q.push_back('{idx, retry, gap});
  endtask

  // gap = cmd_valid-low cycles before the command: ack latency plus GAP.
  task automatic push_seq(input int first_gap);
    for (int i = 0; i < 11; i++) push(i, 0, (i == 0) ? first_gap : c_ACKDLY + c_GAP);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (acc_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("acc_wait_bound", 32'(n < budget), 1);
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(cfg_done || cfg_error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("end_wait_bound", 32'(n < budget), 1);
  endtask

  task automatic pulse_restart();
    @(posedge clk);
    #1 restart = 1'b1;
    @(negedge clk);
    chk("pre_restart_valid", 32'(cmd_valid), 0);
    @(posedge clk);
    #1 restart = 1'b0;
    @(negedge clk);
    chk("restart_valid", 32'(cmd_valid), 1);
    chk("restart_index", 32'(cfg_index), 0);
    chk("restart_flags", {30'd0, cfg_done, cfg_error}, 0);
  endtask

  // Engine model: acks (or not) each accepted command after a fixed latency.
  initial begin : engine
    int id, dly;
    bit ack, silent;
    forever begin
      @(negedge clk);
      if (KEY && cmd_valid && cmd_ready) begin
        id = idx_of(cmd_data1);
        ack = 1'b1;
        silent = 1'b0;
        dly = c_ACKDLY;
        if (id == silent_idx && silent_left > 0) begin
          silent = 1'b1;
          silent_left--;
        end else if (id == nack_idx && nack_left > 0) begin
          ack = 1'b0;
          nack_left--;
        end else if (id == slow_idx && slow_left > 0) begin
          dly = c_TIMEOUT;
          slow_left--;
        end
        @(posedge clk);
        if (!silent) begin
          repeat (dly - 1) @(posedge clk);
          #1;
          xfer_done = 1'b1;
          xfer_ack  = ack;
          @(posedge clk);
          #1;
          xfer_done = 1'b0;
          xfer_ack  = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    logic [23:0] prev;
    logic [15:0] ent;
    bit have_prev;
    int lowcnt;
    have_prev = 1'b0;
    lowcnt = 0;
    forever begin
      @(negedge clk);
      if (!KEY) begin
        lowcnt = 0;
        have_prev = 1'b0;
      end else if (!cmd_valid) begin
        lowcnt++;
        have_prev = 1'b0;
      end else begin
        if (have_prev) chk("hold_stable", {8'd0, cmd_addr, cmd_data1, cmd_data2}, {8'd0, prev});
        if (cmd_ready) begin
          acc_count++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_cmd: got %h/%h/%h idx=%0d expected no command (t=%0t)",
                     cmd_addr, cmd_data1, cmd_data2, cfg_index, $time);
          end else begin
            e = exp_q.pop_front();
            ent = tbl[e.idx];
            chk("cmd", {2'b0, cmd_addr, cmd_data1, cmd_data2, cfg_index, retry_cnt},
                {2'b0, c_ADDR, ent, 4'(e.idx), 2'(e.retry)});
            if (e.gap >= 0) chk("cmd_gap", lowcnt, e.gap);
          end
          lowcnt = 0;
          have_prev = 1'b0;
        end else begin
          prev = {cmd_addr, cmd_data1, cmd_data2};
          have_prev = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : main
    int held, seen, base;
    KEY = 1'b0;
    cmd_ready = 1'b1;
    xfer_done = 1'b0;
    xfer_ack = 1'b0;
    restart = 1'b0;

    // Reset state and full pass
    @(negedge clk);
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_flags", {30'd0, cfg_done, cfg_error}, 0);
    chk("rst_index", 32'(cfg_index), 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    push_seq(c_STARTUP);
    @(posedge clk);
    #1 KEY = 1'b1;
    wait_acc(3, 500);
    // Restart while a transfer is in flight must be ignored.
    @(posedge clk);
    #1 restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
    wait_end(2000);
    chk("p1_done", {30'd0, cfg_done, cfg_error}, 2);
    chk("p1_index", 32'(cfg_index), 10);
    chk("p1_queue", exp_q.size(), 0);

    // Transient NACK: index 3 fails twice then succeeds
    nack_idx = 3;
    nack_left = 2;
    push(0, 0, -1);
    for (int i = 1; i < 3; i++) push(i, 0, c_ACKDLY + c_GAP);
    for (int r = 0; r < 3; r++) push(3, r, c_ACKDLY + c_GAP);
    for (int i = 4; i < 11; i++) push(i, 0, c_ACKDLY + c_GAP);
    pulse_restart();
    wait_end(2000);
    chk("p2_done", {30'd0, cfg_done, cfg_error}, 2);
    chk("p2_retry", 32'(retry_cnt), 0);
    chk("p2_queue", exp_q.size(), 0);

    // Persistent NACK on index 5
    nack_idx = 5;
    nack_left = 1000;
    push(0, 0, -1);
    for (int i = 1; i < 5; i++) push(i, 0, c_ACKDLY + c_GAP);
    for (int r = 0; r <= c_RETRY; r++) push(5, r, c_ACKDLY + c_GAP);
    pulse_restart();
    wait_end(2000);
    chk("p3_flags", {30'd0, cfg_done, cfg_error}, 1);
    chk("p3_index", 32'(cfg_index), 5);
    chk("p3_retry", 32'(retry_cnt), c_RETRY);
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (cmd_valid) seen++;
    end
    chk("p3_no_cmd", seen, 0);
    chk("p3_queue", exp_q.size(), 0);
    nack_left = 0;

    // Backpressure on index 0, timeout on index 2, done-on-expiry on index 4
    cmd_ready = 1'b0;
    silent_idx = 2;
    silent_left = 1;
    slow_idx = 4;
    slow_left = 1;
    push(0, 0, -1);
    push(1, 0, c_ACKDLY + c_GAP);
    push(2, 0, c_ACKDLY + c_GAP);
    push(2, 1, c_TIMEOUT + c_GAP);
    push(3, 0, c_ACKDLY + c_GAP);
    push(4, 0, c_ACKDLY + c_GAP);
    push(5, 0, c_TIMEOUT + c_GAP);
    for (int i = 6; i < 11; i++) push(i, 0, c_ACKDLY + c_GAP);
    pulse_restart();
    held = 0;
    repeat (50) begin
      @(negedge clk);
      if (cmd_valid) held++;
    end
    chk("bp_held", held, 50);
    chk("bp_retry", 32'(retry_cnt), 0);
    @(posedge clk);
    #1 cmd_ready = 1'b1;
    wait_end(3000);
    chk("p4_done", {30'd0, cfg_done, cfg_error}, 2);
    chk("p4_queue", exp_q.size(), 0);

    // Asynchronous reset in WAIT_DONE at index 6, then full rerun
    push_seq(-1);
    base = acc_count;
    pulse_restart();
    wait_acc(base + 7, 1000);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_index", 32'(cfg_index), 6);
    #1 KEY = 1'b0;
    #1;
    chk("async_rst_index", 32'(cfg_index), 0);
    chk("async_rst_valid", 32'(cmd_valid), 0);
    chk("async_rst_retry", 32'(retry_cnt), 0);
    exp_q.delete();
    push_seq(c_STARTUP);
    repeat (3) @(posedge clk);
    #1 KEY = 1'b1;
    wait_end(2000);
    chk("p5_done", {30'd0, cfg_done, cfg_error}, 2);
    chk("p5_index", 32'(cfg_index), 10);
    chk("p5_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
